// File: rtl/pwm_output_stage_if.sv
// Control/status bundle between a duty-word producer and the PWM output stage.
interface pwm_output_stage_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic [CNT_W-1:0] duty_in;
  logic             duty_valid;
  logic             fault;
  logic             fault_clr;
  logic             pwm_out;
  logic             period_start;
  logic [CNT_W-1:0] duty_active;
  logic             faulted;

  modport master (
    output enable, duty_in, duty_valid, fault, fault_clr,
    input  pwm_out, period_start, duty_active, faulted
  );

  modport slave (
    input  enable, duty_in, duty_valid, fault, fault_clr,
    output pwm_out, period_start, duty_active, faulted
  );
endinterface

// File: rtl/pwm_output_stage.sv
// Fixed-frequency PWM driver with period-boundary duty update, slew limit and fault kill.
// pwm_out is registered one cycle after the counter; duty strobes are always accepted (no backpressure).
module pwm_output_stage #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1,
  parameter int SLEW     = 0
) (
  input logic               clk,
  input logic               rst,
  pwm_output_stage_if.slave bus
);
  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] duty_active;
  logic [PW-1:0]    prescaler;
  logic             pwm_q;
  logic             period_start_q;
  logic             tick;
  logic             boundary;
  logic             going_up;
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] duty_next;

  always_comb begin
    next_state = state;
    unique case (state)
      DISABLED: begin
        if (bus.fault)       next_state = FAULT;
        else if (bus.enable) next_state = RUN;
      end
      RUN: begin
        if (bus.fault)        next_state = FAULT;
        else if (!bus.enable) next_state = DISABLED;
      end
      FAULT: begin
        if (bus.fault_clr && !bus.fault) next_state = DISABLED;
      end
      default: next_state = DISABLED;
    endcase
  end

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);

  // Step toward target, clamped to SLEW, so it can neither overshoot nor wrap.
  always_comb begin
    going_up  = (target > duty_active);
    diff      = going_up ? (target - duty_active) : (duty_active - target);
    step      = diff;
    if ((SLEW != 0) && (32'(diff) > 32'(SLEW))) step = CNT_W'(SLEW);
    duty_next = going_up ? (duty_active + step) : (duty_active - step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DISABLED;
      cnt            <= '0;
      prescaler      <= '0;
      target         <= '0;
      duty_active    <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state          <= next_state;
      period_start_q <= 1'b0;
      // Leaving RUN forces the output low on the very next cycle.
      pwm_q          <= (state == RUN) && (next_state == RUN) && (cnt < duty_active);
      if (bus.duty_valid) target <= bus.duty_in;

      if (next_state != RUN) begin
        cnt         <= '0;
        prescaler   <= '0;
        duty_active <= '0;
      end else if (state != RUN) begin
        cnt            <= '0;
        prescaler      <= '0;
        period_start_q <= 1'b1;
        duty_active    <= duty_next;
      end else begin
        prescaler <= tick ? '0 : (prescaler + 1'b1);
        if (tick) cnt <= cnt + 1'b1;
        if (boundary) begin
          period_start_q <= 1'b1;
          duty_active    <= duty_next;
        end
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_active  = duty_active;
  assign bus.faulted      = (state == FAULT);
endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench: two PWM stages (8-bit, prescale 1 / no slew and prescale 4 / slew 16) checked by a scoreboard.
module tb_pwm_output_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst [2];
  logic       en  [2];
  logic [7:0] din [2];
  logic       dvld[2];
  logic       flt [2];
  logic       fclr[2];
  logic       pwm [2];
  logic       ps  [2];
  logic       fltd[2];
  logic [7:0] dact[2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    pwm_output_stage_if #(.CNT_W(8)) bus ();
    assign bus.enable     = en[g];
    assign bus.duty_in    = din[g];
    assign bus.duty_valid = dvld[g];
    assign bus.fault      = flt[g];
    assign bus.fault_clr  = fclr[g];
    assign pwm[g]         = bus.pwm_out;
    assign ps[g]          = bus.period_start;
    assign fltd[g]        = bus.faulted;
    assign dact[g]        = bus.duty_active;

    pwm_output_stage #(
      .CNT_W   (8),
      .PRESCALE((g == 0) ? 1 : 4),
      .SLEW    ((g == 0) ? 0 : 16)
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .bus(bus)
    );
  end

  // duty < 0 marks a deliberately truncated period (fault, disable, reset).
  typedef struct {
    int duty;
    int high;
  } per_t;

  typedef struct {
    int    at;
    int    dut;
    logic  pwm;
    logic  ps;
    int    duty;
    logic  flt;
    string name;
  } snap_t;

  per_t  per_q[2][$];
  snap_t snap_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  function automatic int presc(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int slew(int i);
    return (i == 0) ? 0 : 16;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int    hi[2];
  int    len[2];
  bit    pend_vld[2];
  per_t  pend[2];
  per_t  e;
  snap_t s;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0; len[i] = 0; pend_vld[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (per_q[i].size() > 0 && per_q[i][0].duty < 0) begin
        void'(per_q[i].pop_front());
        pend_vld[i] = 1'b0;
      end
      if (pwm[i] === 1'b1) hi[i]++;
      len[i]++;
      if (ps[i] === 1'b1) begin
        if (pend_vld[i]) begin
          chk($sformatf("dut%0d period_high_cycles", i), hi[i], pend[i].high);
          chk($sformatf("dut%0d period_length", i), len[i], 256 * presc(i));
        end
        pend_vld[i] = 1'b0;
        if (per_q[i].size() == 0) begin
          chk($sformatf("dut%0d unexpected_period_start", i), 1, 0);
        end else begin
          e = per_q[i].pop_front();
          chk($sformatf("dut%0d duty_active_at_period_start", i), int'(dact[i]), e.duty);
          pend[i]     = e;
          pend_vld[i] = 1'b1;
        end
        hi[i]  = 0;
        len[i] = 0;
      end
    end

    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      if (pwm[s.dut] !== s.pwm || ps[s.dut] !== s.ps || fltd[s.dut] !== s.flt ||
          int'(dact[s.dut]) != s.duty) begin
        errors++;
        $display("FAIL dut%0d %s actual pwm=%b ps=%b faulted=%b duty=%0d required pwm=%b ps=%b faulted=%b duty=%0d",
                 s.dut, s.name, pwm[s.dut], ps[s.dut], fltd[s.dut], dact[s.dut],
                 s.pwm, s.ps, s.flt, s.duty);
      end
    end

    if (done || cyc > 95000) begin
      if (!done) chk("run_timeout", cyc, 95000);
      for (int i = 0; i < 2; i++)
        chk($sformatf("dut%0d leftover_periods", i), per_q[i].size(), 0);
      chk("leftover_snapshots", snap_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ps(int i);
    int b = 0;
    do begin
      step(1);
      b++;
    end while (ps[i] !== 1'b1 && b < 512 * presc(i) + 16);
  endtask

  task automatic run_all(int i);
    int n = per_q[i].size();
    repeat (n) wait_ps(i);
  endtask

  task automatic strobe(int i, int d);
    din[i]  = 8'(d);
    dvld[i] = 1'b1;
    step(1);
    dvld[i] = 1'b0;
  endtask

  task automatic push_per(int i, int d);
    per_t p;
    p.duty = d;
    p.high = d * presc(i);
    per_q[i].push_back(p);
  endtask

  task automatic cut(int i);
    per_t p;
    p.duty = -1;
    p.high = 0;
    per_q[i].push_back(p);
  endtask

  task automatic expect_snap(int i, int dt, logic p, logic st, int d, logic f, string nm);
    snap_t x;
    x.at = cyc + dt; x.dut = i; x.pwm = p; x.ps = st; x.duty = d; x.flt = f; x.name = nm;
    snap_q.push_back(x);
  endtask

  // Per-period duty sequence from the slew rule, plus one steady period at the target.
  task automatic ramp(int i, int from, int to);
    int cur = from;
    do begin
      if (slew(i) == 0)   cur = to;
      else if (to > cur)  cur = (cur + slew(i) > to) ? to : cur + slew(i);
      else                cur = (cur - slew(i) < to) ? to : cur - slew(i);
      push_per(i, cur);
    end while (cur != to);
    push_per(i, to);
  endtask

  initial begin
    int d;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; din[i] = '0; dvld[i] = 1'b0; flt[i] = 1'b0; fclr[i] = 1'b0;
    end
    step(2);
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b0, "reset_state");
    expect_snap(1, 1, 1'b0, 1'b0, 0, 1'b0, "reset_state");
    step(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step(1);

    // Basic duty 64, then 0, then full-scale 255.
    strobe(0, 64);
    en[0] = 1'b1;
    expect_snap(0, 1, 1'b0, 1'b1, 64, 1'b0, "run_entry");
    repeat (3) push_per(0, 64);
    run_all(0);
    strobe(0, 0);
    repeat (2) push_per(0, 0);
    run_all(0);
    strobe(0, 255);
    repeat (3) push_per(0, 255);
    run_all(0);

    repeat (4) begin
      d = int'($urandom_range(0, 255));
      strobe(0, d);
      repeat (2) push_per(0, d);
      run_all(0);
    end

    // Later strobe overwrites the earlier one.
    strobe(0, 10);
    strobe(0, 90);
    push_per(0, 90);
    run_all(0);

    // Fault at cnt=10 with duty 128.
    strobe(0, 128);
    push_per(0, 128);
    run_all(0);
    step(10);
    flt[0] = 1'b1;
    cut(0);
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b1, "fault_kill");
    step(1);
    fclr[0] = 1'b1;
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b1, "clr_ignored_while_fault");
    step(1);
    fclr[0] = 1'b0;
    step(2);
    flt[0] = 1'b0;
    step(1);
    fclr[0] = 1'b1;
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b0, "fault_exit_to_disabled");
    expect_snap(0, 2, 1'b0, 1'b1, 128, 1'b0, "reenter_run");
    repeat (2) push_per(0, 128);
    step(1);
    fclr[0] = 1'b0;
    run_all(0);

    // Disable at cnt=5 with duty 200, then re-enable.
    strobe(0, 200);
    push_per(0, 200);
    run_all(0);
    step(5);
    en[0] = 1'b0;
    cut(0);
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b0, "disable_kill");
    step(3);
    en[0] = 1'b1;
    expect_snap(0, 1, 1'b0, 1'b1, 200, 1'b0, "restart_entry");
    repeat (2) push_per(0, 200);
    run_all(0);

    // Reset at cnt=100; target returns to 0, so a strobe on the entry edge is not yet applied.
    step(100);
    rst[0] = 1'b1;
    en[0]  = 1'b0;
    cut(0);
    expect_snap(0, 1, 1'b0, 1'b0, 0, 1'b0, "rst_mid_period");
    step(1);
    rst[0] = 1'b0;
    step(2);
    din[0]  = 8'd77;
    dvld[0] = 1'b1;
    en[0]   = 1'b1;
    expect_snap(0, 1, 1'b0, 1'b1, 0, 1'b0, "entry_uses_old_target");
    push_per(0, 0);
    repeat (2) push_per(0, 77);
    run_all(0);
    dvld[0] = 1'b0;
    en[0]   = 1'b0;
    cut(0);

    // Prescaled, slew-limited instance.
    strobe(1, 200);
    en[1] = 1'b1;
    expect_snap(1, 1, 1'b0, 1'b1, 16, 1'b0, "soft_start_entry");
    ramp(1, 0, 200);
    run_all(1);
    strobe(1, 150);
    ramp(1, 200, 150);
    run_all(1);
    d = int'($urandom_range(0, 255));
    strobe(1, d);
    ramp(1, 150, d);
    run_all(1);
    en[1] = 1'b0;
    cut(1);

    step(3);
    done = 1'b1;
  end
endmodule
